ej32_ss_arb: RTL and testbench

Data-stack controller and arbiter for the eJ32 core. Owns the data-stack pointer and drives the dual-port EBR holding the data stack. Sequences stack operations requested by the arithmetic unit, detects overflow/underflow, and shares the EBR with a debug/monitor port through a four-phase peek/poke handshake. It sits between the AU, the stack EBR and the debug bridge.

---
 rtl/ej32_pkg.sv | 25 ++
 rtl/ej32_ss_dbg_fsm.sv | 82 ++++++++
 rtl/ej32_ss_arb.sv | 157 +++++++++++++++
 tb/tb_ej32_ss_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 data-stack controller.
package ej32_pkg;

  localparam int unsigned SS_DEPTH  = 64;
  localparam int unsigned SS_DSZ    = 32;
  localparam int unsigned SS_STARVE = 8;

  // Stack operation requested by the arithmetic unit
  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPUSH = 2'd1,
    sPOP  = 2'd2,
    sSWAP = 2'd3
  } stack_op;

  // Debug peek/poke sequencer states
  typedef enum logic [2:0] {
    DBG_IDLE = 3'd0,
    DBG_WAIT = 3'd1,
    DBG_ACC  = 3'd2,
    DBG_RD   = 3'd3,
    DBG_ACK  = 3'd4
  } dbg_state_t;

endpackage

// File: rtl/ej32_ss_dbg_fsm.sv
// Debug port sequencer: waits for a free core slot (bounded by STARVE),
// claims the stack EBR for one access and runs the four-phase handshake.
module ej32_ss_dbg_fsm
  import ej32_pkg::*;
#(
  parameter int unsigned STARVE = SS_STARVE
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_we,
  input  logic core_busy,
  output logic stall_c,
  output logic acc_c,
  output logic rd_c,
  output logic ack_c
);

  localparam int unsigned CW = $clog2(STARVE + 1);

  dbg_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DBG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and phase decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    acc_c   = 1'b0;
    rd_c    = 1'b0;
    ack_c   = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (dbg_req) begin
          state_d = DBG_WAIT;
          cnt_d   = '0;
        end
      end
      DBG_WAIT: begin
        if (!core_busy) begin
          state_d = DBG_ACC;
        end else if (cnt_q == CW'(STARVE - 1)) begin
          // Last tolerated busy cycle: hold the core now and take the port next
          stall_c = 1'b1;
          cnt_d   = CW'(STARVE);
          state_d = DBG_ACC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DBG_ACC: begin
        stall_c = 1'b1;
        acc_c   = 1'b1;
        state_d = dbg_we ? DBG_ACK : DBG_RD;
      end
      DBG_RD: begin
        stall_c = 1'b1;
        rd_c    = 1'b1;
        state_d = DBG_ACK;
      end
      DBG_ACK: begin
        ack_c = 1'b1;
        if (!dbg_req) state_d = DBG_IDLE;
      end
      default: begin
        state_d = DBG_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ej32_ss_arb.sv
// eJ32 data-stack controller: owns the stack pointer, sequences AU stack
// operations, tracks overflow/underflow and shares the stack EBR with the
// debug peek/poke port.
module ej32_ss_arb
  import ej32_pkg::*;
#(
  parameter  int unsigned DEPTH  = SS_DEPTH,
  parameter  int unsigned DSZ    = SS_DSZ,
  parameter  int unsigned STARVE = SS_STARVE,
  localparam int unsigned ASZ    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           au_en,
  input  logic [1:0]     au_op,
  input  logic [DSZ-1:0] au_t,
  output logic           au_stall,
  output logic [ASZ-1:0] sp,
  output logic           ss_ren,
  output logic           ss_wen,
  output logic [ASZ-1:0] ss_ra,
  output logic [ASZ-1:0] ss_wa,
  output logic [DSZ-1:0] ss_wd,
  input  logic [DSZ-1:0] ss_rd,
  input  logic           dbg_req,
  input  logic           dbg_we,
  input  logic [ASZ-1:0] dbg_idx,
  input  logic [DSZ-1:0] dbg_wd,
  output logic           dbg_ack,
  output logic [DSZ-1:0] dbg_rd,
  output logic           ovf,
  output logic           unf,
  input  logic           err_clr
);

  stack_op        op;
  logic           stall_c;
  logic           acc_c;
  logic           rd_c;
  logic           ack_c;
  logic           core_busy;
  logic           core_act;
  logic           full;
  logic           empty;
  logic           push_ok;
  logic           push_ovf;
  logic           pop_ok;
  logic           pop_unf;
  logic [ASZ-1:0] sp_inc;
  logic [ASZ-1:0] sp_dec;
  logic [ASZ-1:0] dbg_addr;

  assign op        = stack_op'(au_op);
  assign core_busy = au_en && (op != sNOP);
  // Core ops are dropped while stalled or in reset; the AU re-presents them
  assign core_act  = au_en && !stall_c && !rst;

  assign sp_inc    = sp + ASZ'(1);
  assign sp_dec    = sp - ASZ'(1);
  assign dbg_addr  = sp - dbg_idx;
  assign full      = (sp == ASZ'(DEPTH - 1));
  assign empty     = (sp == '0);

  assign push_ok   = core_act && (op == sPUSH) && !full;
  assign push_ovf  = core_act && (op == sPUSH) && full;
  assign pop_ok    = core_act && (op == sPOP) && !empty;
  assign pop_unf   = core_act && (op == sPOP) && empty;

  ej32_ss_dbg_fsm #(
    .STARVE (STARVE)
  ) u_dbg_fsm (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .core_busy (core_busy),
    .stall_c   (stall_c),
    .acc_c     (acc_c),
    .rd_c      (rd_c),
    .ack_c     (ack_c)
  );

  assign au_stall = stall_c;
  assign dbg_ack  = ack_c;

  // EBR port mux: debug owns the port in ACC, otherwise the core path drives it
  always_comb begin
    ss_ren = 1'b1;
    ss_wen = 1'b0;
    ss_ra  = sp;
    ss_wa  = sp_inc;
    ss_wd  = '0;
    if (acc_c) begin
      if (dbg_we) begin
        // Read side idles during a poke; a peek needs it for the access itself
        ss_ren = 1'b0;
        ss_wen = 1'b1;
        ss_wa  = dbg_addr;
        ss_wd  = dbg_wd;
      end else begin
        ss_ra  = dbg_addr;
      end
    end else if (core_act) begin
      case (op)
        sPUSH: begin
          ss_wd  = au_t;
          ss_wen = !full;
        end
        sPOP: begin
          ss_ra  = sp_dec;
        end
        sSWAP: begin
          ss_wa  = sp;
          ss_ra  = sp_dec;
          ss_wd  = au_t;
          ss_wen = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Stack pointer, held at the bounds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push_ok) begin
      sp <= sp_inc;
    end else if (pop_ok) begin
      sp <= sp_dec;
    end
  end

  // Sticky bound flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push_ovf)     ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (pop_unf)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end

  // Peek data capture, held until the next peek
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rd <= '0;
    end else if (rd_c) begin
      dbg_rd <= ss_rd;
    end
  end

endmodule

// File: tb/tb_ej32_ss_arb.sv
// Self-checking bench for ej32_ss_arb: behavioural stack EBR, directed AU and
// debug stimulus, and a scoreboard that checks every debug acknowledge.
module tb_ej32_ss_arb;

  localparam int unsigned ASZ = 6;
  localparam int unsigned DSZ = 32;
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_SWAP = 2'd3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           au_en = 1'b0;
  logic [1:0]     au_op = OP_NOP;
  logic [DSZ-1:0] au_t = '0;
  logic           au_stall;
  logic [ASZ-1:0] sp;
  logic           ss_ren;
  logic           ss_wen;
  logic [ASZ-1:0] ss_ra;
  logic [ASZ-1:0] ss_wa;
  logic [DSZ-1:0] ss_wd;
  logic [DSZ-1:0] ss_rd = '0;
  logic           dbg_req = 1'b0;
  logic           dbg_we = 1'b0;
  logic [ASZ-1:0] dbg_idx = '0;
  logic [DSZ-1:0] dbg_wd = '0;
  logic           dbg_ack;
  logic [DSZ-1:0] dbg_rd;
  logic           ovf;
  logic           unf;
  logic           err_clr = 1'b0;

  always #5 clk = ~clk;

  ej32_ss_arb dut (
    .clk      (clk),
    .rst      (rst),
    .au_en    (au_en),
    .au_op    (au_op),
    .au_t     (au_t),
    .au_stall (au_stall),
    .sp       (sp),
    .ss_ren   (ss_ren),
    .ss_wen   (ss_wen),
    .ss_ra    (ss_ra),
    .ss_wa    (ss_wa),
    .ss_wd    (ss_wd),
    .ss_rd    (ss_rd),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_idx  (dbg_idx),
    .dbg_wd   (dbg_wd),
    .dbg_ack  (dbg_ack),
    .dbg_rd   (dbg_rd),
    .ovf      (ovf),
    .unf      (unf),
    .err_clr  (err_clr)
  );

  // Behavioural dual-port stack EBR with registered read
  logic [DSZ-1:0] mem [64] = '{default: '0};
  always @(posedge clk) begin
    if (ss_wen) mem[ss_wa] <= ss_wd;
    if (ss_ren) ss_rd <= mem[ss_ra];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DSZ-1:0] rd;
    int             lat;
    int             stalls;
    int             start;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   fs = 0;

  task automatic chk(input string name, input logic [DSZ-1:0] act, input logic [DSZ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the expected response on each rising dbg_ack and compares it
  task automatic monitor();
    logic ack_d = 1'b0;
    int   stalls = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0 && au_stall) stalls++;
      if (dbg_ack && !ack_d) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("dbg_rd", dbg_rd, e.rd);
          chk("ack_latency", 32'(cyc - e.start), 32'(e.lat));
          chk("stall_cycles", 32'(stalls), 32'(e.stalls));
        end
        stalls = 0;
      end
      ack_d = dbg_ack;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [DSZ-1:0] t, input logic clr);
    au_en   = 1'b1;
    au_op   = op;
    au_t    = t;
    err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    au_en   = 1'b0;
    au_op   = OP_NOP;
    au_t    = '0;
    err_clr = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [ASZ-1:0] idx, input logic [DSZ-1:0] wd,
                            input logic early, input logic [DSZ-1:0] exp_rd,
                            input int exp_lat, input int exp_stalls);
    exp_t e;
    int   n;
    e.rd     = exp_rd;
    e.lat    = exp_lat;
    e.stalls = exp_stalls;
    e.start  = cyc;
    sbq.push_back(e);
    dbg_we  = we;
    dbg_idx = idx;
    dbg_wd  = wd;
    dbg_req = 1'b1;
    if (early) begin
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
    end
    n = 0;
    while (!dbg_ack && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!dbg_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
    end
    dbg_req = 1'b0;
    @(posedge clk);
    #1;
    chk1("ack_release", dbg_ack, 1'b0);
  endtask

  // Pushes n values back to back, re-presenting any push held by a stall
  task automatic push_stream(input int n, input logic [DSZ-1:0] base, input int start,
                             output int first_stall);
    int acc = 0;
    first_stall = -1;
    for (int i = 0; i < 40 && acc < n; i++) begin
      au_en = 1'b1;
      au_op = OP_PUSH;
      au_t  = base + DSZ'(acc);
      #1;
      if (au_stall) begin
        if (first_stall < 0) first_stall = cyc - start;
      end else begin
        acc++;
      end
      @(posedge clk);
      #1;
    end
    au_en = 1'b0;
    au_op = OP_NOP;
    au_t  = '0;
    chk("pushes_accepted", 32'(acc), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    #2;
    chk("rst_sp", 32'(sp), 32'd0);
    chk1("rst_stall", au_stall, 1'b0);
    chk1("rst_wen", ss_wen, 1'b0);
    chk1("rst_ren", ss_ren, 1'b1);
    chk("rst_ra", 32'(ss_ra), 32'd0);
    chk("rst_wa", 32'(ss_wa), 32'd1);
    chk("rst_wd", ss_wd, 32'd0);
    chk1("rst_ack", dbg_ack, 1'b0);
    chk("rst_dbg_rd", dbg_rd, 32'd0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_unf", unf, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Push / pop
    drive(OP_PUSH, 32'h11, 1'b0);
    #1;
    chk1("push_wen", ss_wen, 1'b1);
    chk("push_wa", 32'(ss_wa), 32'd1);
    chk("push_wd", ss_wd, 32'h11);
    tick();
    drive(OP_PUSH, 32'h22, 1'b0); tick();
    drive(OP_PUSH, 32'h33, 1'b0); tick();
    chk("push_sp", 32'(sp), 32'd3);
    chk("mem1", mem[1], 32'h11);
    chk("mem2", mem[2], 32'h22);
    chk("mem3", mem[3], 32'h33);
    drive(OP_POP, '0, 1'b0);
    #1;
    chk("pop_ra", 32'(ss_ra), 32'd2);
    tick();
    drive(OP_POP, '0, 1'b0); tick();
    chk("pop_sp", 32'(sp), 32'd1);
    chk1("pop_ovf", ovf, 1'b0);
    chk1("pop_unf", unf, 1'b0);

    // Peek idx 1 with core idle
    drive(OP_PUSH, 32'h22, 1'b0); tick();
    drive(OP_PUSH, 32'h33, 1'b0); tick();
    dbg_access(1'b0, 6'd1, '0, 1'b0, 32'h22, 4, 2);
    chk("peek_sp", 32'(sp), 32'd3);

    // Poke idx 2 with core idle; dbg_rd holds the last peek
    dbg_access(1'b1, 6'd2, 32'hBEEF, 1'b0, 32'h22, 3, 1);
    chk("poke_mem1", mem[1], 32'hBEEF);
    chk("poke_sp", 32'(sp), 32'd3);

    // Starvation: poke pending under continuous pushes
    fork
      dbg_access(1'b1, 6'd0, 32'hDEAD, 1'b0, 32'h22, 10, 2);
      push_stream(9, 32'h100, cyc, fs);
    join
    chk("starve_first_stall", 32'(fs), 32'd8);
    chk("starve_mem11", mem[11], 32'hDEAD);
    chk("starve_mem12", mem[12], 32'h108);
    chk("starve_mem4", mem[4], 32'h100);
    chk("starve_sp", 32'(sp), 32'd12);

    // Peek with the request dropped early
    dbg_access(1'b0, 6'd1, '0, 1'b1, 32'hDEAD, 4, 2);

    // Swap
    drive(OP_SWAP, 32'h5A, 1'b0);
    #1;
    chk1("swap_wen", ss_wen, 1'b1);
    chk("swap_wa", 32'(ss_wa), 32'd12);
    chk("swap_ra", 32'(ss_ra), 32'd11);
    tick();
    chk("swap_mem12", mem[12], 32'h5A);
    chk("swap_sp", 32'(sp), 32'd12);

    // Overflow
    for (int i = 0; i < 51; i++) begin
      drive(OP_PUSH, DSZ'(i), 1'b0);
      tick();
    end
    chk("full_sp", 32'(sp), 32'd63);
    drive(OP_PUSH, 32'hFFFF, 1'b0);
    #1;
    chk1("ovf_wen", ss_wen, 1'b0);
    tick();
    chk1("ovf_set", ovf, 1'b1);
    chk("ovf_sp", 32'(sp), 32'd63);
    chk("ovf_mem0", mem[0], 32'd0);
    drive(OP_NOP, '0, 1'b1); tick();
    chk1("ovf_clr", ovf, 1'b0);

    // Underflow
    rst = 1'b1;
    #1;
    chk("async_rst_sp", 32'(sp), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(OP_POP, '0, 1'b0); tick();
    chk1("unf_set", unf, 1'b1);
    chk("unf_sp", 32'(sp), 32'd0);
    drive(OP_POP, '0, 1'b1); tick();
    chk1("unf_set_beats_clr", unf, 1'b1);
    drive(OP_NOP, '0, 1'b1); tick();
    chk1("unf_clr", unf, 1'b0);

    // Reset during RD of a peek
    drive(OP_PUSH, 32'h77, 1'b0); tick();
    drive(OP_PUSH, 32'h78, 1'b0); tick();
    dbg_we  = 1'b0;
    dbg_idx = '0;
    dbg_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk1("rd_phase_stall", au_stall, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_stall", au_stall, 1'b0);
    chk1("midrst_ack", dbg_ack, 1'b0);
    chk("midrst_sp", 32'(sp), 32'd0);
    chk("midrst_dbg_rd", dbg_rd, 32'd0);
    dbg_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(OP_PUSH, 32'h77, 1'b0); tick();
    dbg_access(1'b0, 6'd0, '0, 1'b0, 32'h77, 4, 2);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
